// File: rtl/axi_stream_fifo.sv
// AXI4-Stream FIFO (TDATA/TLAST/TUSER) with registered head-of-queue outputs.
// Optional packet mode: define AXIS_FIFO_PACKET_MODE_EN to hold m_tValid until a whole packet is stored.
module axi_stream_fifo #(
  parameter int WIDTH   = 16,
  parameter int UNITS   = 1,
  parameter int TUSER_W = 1,
  parameter int DEPTH   = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_tValid,
  output logic                     s_tReady,
  input  logic [WIDTH*UNITS-1:0]   s_tData,
  input  logic                     s_tLast,
  input  logic [TUSER_W-1:0]       s_tUser,
  output logic                     m_tValid,
  input  logic                     m_tReady,
  output logic [WIDTH*UNITS-1:0]   m_tData,
  output logic                     m_tLast,
  output logic [TUSER_W-1:0]       m_tUser,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int DW = WIDTH * UNITS;
  localparam int EW = DW + 1 + TUSER_W;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] count_reg, count_next;
  logic          s_ready_reg, m_valid_reg, m_valid_next;
  logic [EW-1:0] head_reg, head_next;
  logic          push, pop, full_next, load_head;

  assign push = s_tValid && s_ready_reg;
  assign pop  = m_valid_reg && m_tReady;

  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
  assign count_next  = wr_ptr_next - rd_ptr_next;
  assign full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                       (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

  // The head register tracks mem[rd_ptr]; a beat landing in the slot that becomes the head is forwarded.
  assign load_head = pop || (push && (rd_ptr_reg == wr_ptr_reg));
  assign head_next = (push && (wr_ptr_reg == rd_ptr_next)) ? {s_tData, s_tLast, s_tUser}
                                                           : mem[rd_ptr_next[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {s_tData, s_tLast, s_tUser};
    end
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [PW-1:0] pkt_reg, pkt_next;
  logic          last_in, last_out;

  assign last_in  = push && s_tLast;
  assign last_out = pop && m_tLast;

  always_comb begin
    pkt_next = pkt_reg;
    if (last_in && !last_out) begin
      pkt_next = pkt_reg + PW'(1);
    end else if (!last_in && last_out) begin
      pkt_next = pkt_reg - PW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_reg <= '0;
    end else begin
      pkt_reg <= pkt_next;
    end
  end

  // Full also releases the head so a packet longer than the FIFO cannot deadlock.
  always_comb begin
    m_valid_next = 1'b0;
    if (count_next != '0) begin
      m_valid_next = (pkt_next != '0) || (count_next == FULL_CNT) || (m_valid_reg && !pop);
    end
  end
`else
  always_comb begin
    m_valid_next = (count_next != '0);
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      s_ready_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      head_reg    <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      s_ready_reg <= !full_next;
      m_valid_reg <= m_valid_next;
      if (load_head) begin
        head_reg <= head_next;
      end
    end
  end

  assign s_tReady = s_ready_reg;
  assign m_tValid = m_valid_reg;
  assign m_tData  = head_reg[EW-1 -: DW];
  assign m_tLast  = head_reg[TUSER_W];
  assign m_tUser  = head_reg[TUSER_W-1:0];
  assign count    = count_reg;

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Directed-vector bench for axi_stream_fifo (default parameters, optional packet mode).
module tb_axi_stream_fifo;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_tValid = 1'b0;
  logic        s_tReady;
  logic [15:0] s_tData = '0;
  logic        s_tLast = 1'b0;
  logic [0:0]  s_tUser = '0;
  logic        m_tValid;
  logic        m_tReady = 1'b0;
  logic [15:0] m_tData;
  logic        m_tLast;
  logic [0:0]  m_tUser;
  logic [4:0]  count;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  axi_stream_fifo #(.WIDTH(16), .UNITS(1), .TUSER_W(1), .DEPTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tValid(s_tValid), .s_tReady(s_tReady), .s_tData(s_tData),
    .s_tLast(s_tLast), .s_tUser(s_tUser),
    .m_tValid(m_tValid), .m_tReady(m_tReady), .m_tData(m_tData),
    .m_tLast(m_tLast), .m_tUser(m_tUser), .count(count)
  );

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        sl;
    logic        su;
    logic        mr;
    logic        emv;
    logic [15:0] emd;
    logic        eml;
    logic        emu;
    logic [4:0]  ecnt;
    logic        esr;
  } vec_t;

  vec_t tbl [64];
  int   n_vec = 0;

  task automatic add_vec(input logic sv, input logic [15:0] sd, input logic sl, input logic su,
                         input logic mr, input logic emv, input logic [15:0] emd, input logic eml,
                         input logic emu, input logic [4:0] ecnt, input logic esr);
    tbl[n_vec] = '{sv, sd, sl, su, mr, emv, emd, eml, emu, ecnt, esr};
    n_vec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  logic [17:0] sb_q [$];
  logic [17:0] held, expv;
  logic        stall, do_push, do_pop, pm;
  int          pushed, popped, cyc;

  initial begin
`ifdef AXIS_FIFO_PACKET_MODE_EN
    pm = 1'b1;
`else
    pm = 1'b0;
`endif
    // Reset then single beat
    add_vec(0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 0, 5'd0, 1);
    add_vec(1, 16'h1234, 1, 1, 0,  1, 16'h1234, 1, 1, 5'd1, 1);
    add_vec(0, 16'h0000, 0, 0, 0,  1, 16'h1234, 1, 1, 5'd1, 1);
    add_vec(0, 16'h0000, 0, 0, 1,  0, 16'h0000, 0, 0, 5'd0, 1);
    // Fill to full with the sink stalled; beat 15 closes the packet
    for (int k = 0; k < 16; k++) begin
      add_vec(1, 16'(k), (k == 15), k[0], 0, pm ? (k == 15) : 1'b1, 16'h0000, 0, 0,
              5'(k + 1), (k != 15));
    end
    add_vec(1, 16'h0010, 1, 0, 0,  1, 16'h0000, 0, 0, 5'd16, 0);
    add_vec(1, 16'h0010, 1, 0, 1,  1, 16'h0001, 0, 1, 5'd15, 1);
    add_vec(1, 16'h0010, 1, 0, 1,  1, 16'h0002, 0, 0, 5'd15, 1);
    for (int j = 1; j <= 15; j++) begin
      if (j <= 13)
        add_vec(0, 16'h0000, 0, 0, 1, 1, 16'(2 + j), (2 + j == 15), j[0], 5'(15 - j), 1);
      else if (j == 14)
        add_vec(0, 16'h0000, 0, 0, 1, 1, 16'h0010, 1, 0, 5'd1, 1);
      else
        add_vec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 5'd0, 1);
    end

    #12;
    chk("reset_count", 32'(count), 0);
    chk("reset_m_valid", 32'(m_tValid), 0);
    chk("reset_s_ready", 32'(s_tReady), 0);
    chk("reset_m_data", 32'({m_tData, m_tLast, m_tUser}), 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      s_tValid = tbl[i].sv;
      s_tData  = tbl[i].sd;
      s_tLast  = tbl[i].sl;
      s_tUser  = tbl[i].su;
      m_tReady = tbl[i].mr;
      tick();
      $display("vec %0d: sv=%0b sd=%h mr=%0b -> mv=%0b md=%h cnt=%0d sr=%0b",
               i, tbl[i].sv, tbl[i].sd, tbl[i].mr, m_tValid, m_tData, count, s_tReady);
      chk($sformatf("vec%0d_m_valid", i), 32'(m_tValid), 32'(tbl[i].emv));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
      chk($sformatf("vec%0d_s_ready", i), 32'(s_tReady), 32'(tbl[i].esr));
      if (tbl[i].emv) begin
        chk($sformatf("vec%0d_m_beat", i), 32'({m_tData, m_tLast, m_tUser}),
            32'({tbl[i].emd, tbl[i].eml, tbl[i].emu}));
      end
    end

    // Streaming: one beat per cycle, occupancy pinned at 1
    s_tValid = 1'b1; s_tLast = 1'b1; s_tUser = '0; m_tReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tData = 16'(16'h0100 + i);
      tick();
      $display("stream %0d: in=%h out=%h mv=%0b cnt=%0d", i, s_tData, m_tData, m_tValid, count);
      chk("stream_beat", {m_tValid, count, 10'd0, m_tData}, {1'b1, 5'd1, 10'd0, 16'(16'h0100 + i)});
    end
    s_tValid = 1'b0;
    tick();
    chk("stream_drain_count", 32'(count), 0);

    // Random back-pressure against a scoreboard
    pushed = 0; popped = 0; cyc = 0; stall = 1'b0; held = '0;
    while (popped < 1000 && cyc < 30000) begin
      s_tValid = (pushed < 1000) && ($urandom_range(0, 9) < 7);
      s_tData  = 16'($urandom);
      s_tLast  = (pushed == 999) || ($urandom_range(0, 3) == 0);
      s_tUser  = 1'($urandom);
      m_tReady = ($urandom_range(0, 9) < 6);
      do_push  = s_tValid && s_tReady;
      do_pop   = m_tValid && m_tReady;
      if (do_pop) begin
        if (sb_q.size() == 0) begin
          chk("rand_underflow", 32'(sb_q.size()), 1);
        end else begin
          expv = sb_q.pop_front();
          $display("rand pop %0d: got=%h want=%h", popped, {m_tData, m_tLast, m_tUser}, expv);
          chk("rand_beat", 32'({m_tData, m_tLast, m_tUser}), 32'(expv));
        end
        popped++;
      end
      if (do_push) begin
        sb_q.push_back({s_tData, s_tLast, s_tUser});
        pushed++;
      end
      stall = m_tValid && !m_tReady;
      held  = {m_tData, m_tLast, m_tUser};
      tick();
      cyc++;
      if (stall) chk("rand_stall", 32'({m_tValid, m_tData, m_tLast, m_tUser}), 32'({1'b1, held}));
      chk("rand_count", 32'(count), 32'(sb_q.size()));
    end
    chk("rand_done", popped, 1000);
    s_tValid = 1'b0; m_tReady = 1'b0;

    // Mid-operation reset
    for (int i = 0; i < 7; i++) begin
      s_tValid = 1'b1; s_tData = 16'(16'h0200 + i); s_tLast = 1'b1; s_tUser = '0;
      tick();
    end
    s_tValid = 1'b0;
    tick();
    chk("midrst_pre_count", 32'(count), 7);
    #2 aresetn = 1'b0;
    #1;
    $display("midrst: mv=%0b sr=%0b cnt=%0d", m_tValid, s_tReady, count);
    chk("midrst_async", 32'({m_tValid, s_tReady, count}), 0);
    tick();
    chk("midrst_hold_s_ready", 32'(s_tReady), 0);
    aresetn = 1'b1;
    tick();
    chk("midrst_release_s_ready", 32'({s_tReady, m_tValid}), 32'(2'b10));
    s_tValid = 1'b1; s_tData = 16'hABCD; s_tLast = 1'b1; s_tUser = 1'b1;
    tick();
    chk("midrst_first_beat", 32'({m_tValid, m_tData, m_tLast, m_tUser}), 32'({1'b1, 16'hABCD, 1'b1, 1'b1}));
    s_tValid = 1'b0; m_tReady = 1'b1;
    tick();
    chk("midrst_drain", 32'({m_tValid, count}), 0);

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Packet held back until its last beat arrives
    m_tReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tValid = 1'b1; s_tData = 16'(16'h0300 + i); s_tLast = (i == 2); s_tUser = '0;
      tick();
      if (i < 2) chk("pkt_hold_m_valid", 32'(m_tValid), 0);
    end
    chk("pkt_release", 32'({m_tValid, m_tData}), 32'({1'b1, 16'h0300}));
    s_tValid = 1'b0;
    tick();
    chk("pkt_beat1", 32'({m_tValid, m_tData, m_tLast}), 32'({1'b1, 16'h0301, 1'b0}));
    tick();
    chk("pkt_beat2", 32'({m_tValid, m_tData, m_tLast}), 32'({1'b1, 16'h0302, 1'b1}));
    tick();
    chk("pkt_empty", 32'({m_tValid, count}), 0);

    // Oversize packet released by the full condition
    m_tReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_tValid = 1'b1; s_tData = 16'(16'h0400 + i); s_tLast = 1'b0;
      tick();
      if (i == 14) chk("pkt_long_m_valid_15", 32'(m_tValid), 0);
    end
    chk("pkt_long_full", 32'({m_tValid, count}), 32'({1'b1, 5'd16}));
    s_tValid = 1'b0; m_tReady = 1'b1;
    tick();
    s_tValid = 1'b1; s_tData = 16'h04FF; s_tLast = 1'b1;
    tick();
    s_tValid = 1'b0;
    cyc = 0;
    while (count != 0 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("pkt_long_drain", 32'(count), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_stream_fifo.md
Name: axi_stream_fifo

Overview:
- Synchronous AXI4-Stream FIFO for the continuous aligned stream form. Carries TDATA, TLAST and TUSER only.
- Sits directly upstream of a processing stage that consumes the stream. Absorbs producer bursts and decouples TREADY back-pressure between the two sides.
- Slave side accepts beats; master side presents them in order with AXI4-Stream valid/ready semantics.

Parameters:
- WIDTH, 16, width of each unit in bits; must be a multiple of 8.
- UNITS, 1, number of units per beat; BYTES = (WIDTH/8)*UNITS.
- TUSER_W, 1, width of the user sideband; minimum 1.
- DEPTH, 16, number of beats stored; power of two, >= 2.

Ports:
- aclk  input  1  global clock; all logic on the rising edge.
- aresetn  input  1  global reset, asynchronous assert, active LOW.
- s_tValid  input  1  slave beat valid.
- s_tReady  output  1  FIFO can accept a beat.
- s_tData  input  8*BYTES  slave data.
- s_tLast  input  1  slave packet boundary.
- s_tUser  input  TUSER_W  slave sideband.
- m_tValid  output  1  master beat valid.
- m_tReady  input  1  downstream ready.
- m_tData  output  8*BYTES  master data.
- m_tLast  output  1  master packet boundary.
- m_tUser  output  TUSER_W  master sideband.
- count  output  $clog2(DEPTH)+1  beats currently stored, 0..DEPTH.

Behaviour:
- Clocking and reset: one clock, aclk. Reset aresetn is asynchronous and active-low.
- Reset values, applied while aresetn is low:
  - count = 0, m_tValid = 0, s_tReady = 0.
  - m_tData, m_tLast and m_tUser = 0.
  - Read and write pointers = 0.
- After reset: s_tReady rises on the first aclk edge after aresetn deasserts.
- Reset mid-operation: all stored beats are discarded and no partial beat is emitted. Upstream sees s_tReady drop asynchronously.
- Push: a beat is written when s_tValid && s_tReady on a rising edge.
- Pop: a beat is read when m_tValid && m_tReady on a rising edge.
- Storage: DEPTH-entry array holding {tData, tLast, tUser}.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
  - Array index is the low $clog2(DEPTH) bits.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the low bits are equal.
- s_tReady = !full, registered.
  - At count = DEPTH, s_tReady = 0.
  - A pop while full raises s_tReady on the next edge. A simultaneous push in that cycle is impossible because s_tReady was 0.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. It never exceeds DEPTH or goes below 0.
- Latency: a beat pushed on edge N is visible with m_tValid = 1 after edge N. There is no combinational path from s_* to m_*, nor from m_tReady to s_tReady.
- Empty FIFO: a push and a pop cannot coincide, because there is no bypass.
- Master stability: while m_tValid && !m_tReady, m_tData, m_tLast and m_tUser hold stable and m_tValid stays 1.
- Ordering: beats leave in exact push order, with tLast and tUser bit-exact.
- Outputs are registered from storage. A back-to-back pop stream sustains 1 beat/cycle when count >= 1.
- Full-throughput requirement: continuous s_tValid = 1 with m_tReady = 1 gives 1 beat/cycle after the initial latency.

Optional Feature:
- Macro: AXIS_FIFO_PACKET_MODE_EN.
- Defined (packet mode):
  - An internal packet counter, 0..DEPTH, increments on a push with s_tLast = 1 and decrements on a pop with m_tLast = 1. A simultaneous push and pop of tLast leaves it unchanged.
  - m_tValid asserts only when the packet counter > 0 or count = DEPTH. The full case prevents deadlock on packets longer than DEPTH.
  - Once a beat is presented, m_tValid stays high until the handshake completes.
- Not defined: m_tValid = !empty; no packet counter logic is synthesized.

Test Plan:
- Reset then single beat:
  - Stimulus: release aresetn; push tData=0x1234, tLast=1, tUser=1.
  - Required: s_tReady=1 one edge after release; m_tValid=1 one edge after the push with identical fields; count goes 0->1->0 after the pop.
- Fill to full with m_tReady=0:
  - Stimulus: push 16 beats 0x0000..0x000F.
  - Required: count=16; s_tReady=0; a 17th beat is held by upstream and not lost.
  - Then assert m_tReady: beats 0x0000..0x000F emerge in order, and s_tReady=1 one edge after the first pop.
- Streaming:
  - Stimulus: s_tValid=1 and m_tReady=1 for 100 cycles with an incrementing counter.
  - Required: output equals input delayed by one cycle; count stays at 1; zero gaps after the first beat.
- Random back-pressure:
  - Stimulus: random s_tValid and m_tReady, with 1000 beats across multiple pointer wraps.
  - Required: a scoreboard matches every beat, including tLast and tUser; m_* stays stable while stalled.
- Mid-operation reset:
  - Stimulus: count=7, then pulse aresetn low between edges.
  - Required: m_tValid, s_tReady and count go to 0 immediately. After release, the first new pushed beat is the first beat output.
- Packet mode (AXIS_FIFO_PACKET_MODE_EN defined):
  - Stimulus 1: push 3 beats with tLast only on the third.
    - Required: m_tValid stays 0 until the third push, then 3 beats follow.
  - Stimulus 2: push 16 beats with no tLast.
    - Required: m_tValid=1 at count=16.
